// File: rtl/ppm_frame_tx.sv
// ppm_frame_tx: framed L-PPM transmitter with an input byte FIFO.
// Each frame is SOF (8 slots), frame_len bytes sent as 8/M symbols, then EOF (4 slots).
//
// state  | meaning
// IDLE   | waiting for an acceptable start
// SOF    | 8-slot start-of-frame pattern, pulses in slots 0 and 5
// DATA   | PPM symbols, LSB symbol of each byte first
// EOF    | 4-slot end-of-frame pattern, pulse in slot 2
module ppm_frame_tx #(
  parameter int BITS_PER_SYM = 2,
  parameter int SLOT_CYCLES  = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int LEN_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  output logic             err_start,
  output logic [LEN_W-1:0] fifo_count,
  output logic             dout
);

  localparam int M     = BITS_PER_SYM;
  localparam int SPS   = 2 ** (M + 1);
  localparam int SYMS  = 8 / M;
  localparam int SC_W  = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2((SPS > 8) ? SPS : 8);
  localparam int SYM_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (!(M == 1 || M == 2 || M == 4)) begin : g_bad_m
    $error("ppm_frame_tx: BITS_PER_SYM must be 1, 2 or 4");
  end
  if (SLOT_CYCLES < 2) begin : g_bad_s
    $error("ppm_frame_tx: SLOT_CYCLES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_d
    $error("ppm_frame_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((2 ** LEN_W) <= FIFO_DEPTH) begin : g_bad_len
    $error("ppm_frame_tx: LEN_W too narrow for FIFO_DEPTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_SOF, S_DATA, S_EOF} state_t;

  state_t             state, state_n;
  logic [SC_W-1:0]    slot_cnt, slot_cnt_n;
  logic [IDX_W-1:0]   slot_idx, slot_idx_n;
  logic [SYM_W-1:0]   sym_cnt, sym_cnt_n;
  logic [LEN_W-1:0]   byte_cnt, byte_cnt_n;
  logic [LEN_W-1:0]   len_q;
  logic [7:0]         shreg;
  logic [IDX_W-1:0]   pulse_slot;
  logic               slot_end, accept, push, pop, shift;
  logic               dout_n, done_n, err_n;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  assign s_ready    = fifo_count < LEN_W'(FIFO_DEPTH);
  assign push       = s_valid && s_ready;
  assign busy       = (state != S_IDLE);
  assign slot_end   = (slot_cnt == SC_W'(SLOT_CYCLES - 1));
  assign pulse_slot = IDX_W'({shreg[M-1:0], 1'b1});

  // Acceptance guarantees every byte of the frame is already buffered.
  assign accept = start && (state == S_IDLE) && (frame_len != '0) &&
                  (frame_len <= LEN_W'(FIFO_DEPTH)) && (fifo_count >= frame_len);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + LEN_W'(1);
        2'b01:   fifo_count <= fifo_count - LEN_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    slot_cnt_n = slot_cnt;
    slot_idx_n = slot_idx;
    sym_cnt_n  = sym_cnt;
    byte_cnt_n = byte_cnt;
    pop        = 1'b0;
    shift      = 1'b0;
    done_n     = 1'b0;
    err_n      = start && !accept;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n    = S_SOF;
          slot_cnt_n = '0;
          slot_idx_n = '0;
        end
      end
      S_SOF: begin
        if (!slot_end) begin
          slot_cnt_n = slot_cnt + SC_W'(1);
        end else begin
          slot_cnt_n = '0;
          if (slot_idx == IDX_W'(7)) begin
            state_n    = S_DATA;
            slot_idx_n = '0;
            sym_cnt_n  = '0;
            byte_cnt_n = '0;
          end else begin
            slot_idx_n = slot_idx + IDX_W'(1);
          end
        end
      end
      S_DATA: begin
        pop = (slot_cnt == '0) && (slot_idx == '0) && (sym_cnt == '0);
        if (!slot_end) begin
          slot_cnt_n = slot_cnt + SC_W'(1);
        end else begin
          slot_cnt_n = '0;
          if (slot_idx == IDX_W'(SPS - 1)) begin
            slot_idx_n = '0;
            shift      = 1'b1;
            if (sym_cnt == SYM_W'(SYMS - 1)) begin
              sym_cnt_n = '0;
              if (byte_cnt == len_q - LEN_W'(1)) begin
                state_n = S_EOF;
              end else begin
                byte_cnt_n = byte_cnt + LEN_W'(1);
              end
            end else begin
              sym_cnt_n = sym_cnt + SYM_W'(1);
            end
          end else begin
            slot_idx_n = slot_idx + IDX_W'(1);
          end
        end
      end
      S_EOF: begin
        if (!slot_end) begin
          slot_cnt_n = slot_cnt + SC_W'(1);
        end else begin
          slot_cnt_n = '0;
          if (slot_idx == IDX_W'(3)) begin
            state_n    = S_IDLE;
            slot_idx_n = '0;
            done_n     = 1'b1;
          end else begin
            slot_idx_n = slot_idx + IDX_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // dout is registered, so it is decoded from the position being entered.
  // Slot 0 of a symbol is never a pulse, which hides the shift-register load.
  always_comb begin
    dout_n = 1'b1;
    case (state_n)
      S_SOF:   dout_n = !((slot_idx_n == '0) || (slot_idx_n == IDX_W'(5)));
      S_DATA:  dout_n = (slot_idx_n != pulse_slot);
      S_EOF:   dout_n = (slot_idx_n != IDX_W'(2));
      default: dout_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      slot_cnt  <= '0;
      slot_idx  <= '0;
      sym_cnt   <= '0;
      byte_cnt  <= '0;
      len_q     <= '0;
      shreg     <= '0;
      dout      <= 1'b1;
      done      <= 1'b0;
      err_start <= 1'b0;
    end else begin
      state     <= state_n;
      slot_cnt  <= slot_cnt_n;
      slot_idx  <= slot_idx_n;
      sym_cnt   <= sym_cnt_n;
      byte_cnt  <= byte_cnt_n;
      dout      <= dout_n;
      done      <= done_n;
      err_start <= err_n;
      if (accept) len_q <= frame_len;
      if (pop)        shreg <= mem[rd_ptr];
      else if (shift) shreg <= shreg >> M;
    end
  end

endmodule

// File: tb/tb_ppm_frame_tx.sv
// Bench for ppm_frame_tx: three instances (M=2/S=16, M=1/S=4, M=4/S=4) checked every
// cycle against an arithmetic frame model, plus literal pulse positions per frame.
module tb_ppm_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data [3];
  logic       s_valid [3];
  logic       start [3];
  logic [4:0] frame_len [3];
  logic       s_ready [3];
  logic       busy [3];
  logic       done [3];
  logic       err_start [3];
  logic [4:0] fifo_count [3];
  logic       dout [3];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ppm_frame_tx #(.BITS_PER_SYM(2), .SLOT_CYCLES(16), .FIFO_DEPTH(16), .LEN_W(5)) u_m2 (
    .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .start(start[0]), .frame_len(frame_len[0]), .busy(busy[0]), .done(done[0]),
    .err_start(err_start[0]), .fifo_count(fifo_count[0]), .dout(dout[0]));

  ppm_frame_tx #(.BITS_PER_SYM(1), .SLOT_CYCLES(4), .FIFO_DEPTH(16), .LEN_W(5)) u_m1 (
    .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .start(start[1]), .frame_len(frame_len[1]), .busy(busy[1]), .done(done[1]),
    .err_start(err_start[1]), .fifo_count(fifo_count[1]), .dout(dout[1]));

  ppm_frame_tx #(.BITS_PER_SYM(4), .SLOT_CYCLES(4), .FIFO_DEPTH(16), .LEN_W(5)) u_m4 (
    .clk(clk), .rst(rst), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .start(start[2]), .frame_len(frame_len[2]), .busy(busy[2]), .done(done[2]),
    .err_start(err_start[2]), .fifo_count(fifo_count[2]), .dout(dout[2]));

  // ---------------- behavioural model ----------------
  logic [7:0] mbuf [3][256];
  logic [7:0] fbytes [3][16];
  int         mhead [3], mtail [3], fcyc [3], flen [3];
  bit         fact [3], mdone [3], merr [3];

  function automatic int sc(int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int mb(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic int frame_total(int i, int len);
    return sc(i) * (8 + len * (8 / mb(i)) * (2 ** (mb(i) + 1)) + 4);
  endfunction

  function automatic int pop_time(int i, int b);
    return sc(i) * (8 + b * (8 / mb(i)) * (2 ** (mb(i) + 1)));
  endfunction

  function automatic bit exp_dout(int i, int c);
    int m, sps, syms, slot, sym, v, ds;
    m = mb(i); sps = 2 ** (m + 1); syms = 8 / m;
    slot = c / sc(i);
    if (slot < 8) return !(slot == 0 || slot == 5);
    slot = slot - 8;
    ds = flen[i] * syms * sps;
    if (slot < ds) begin
      sym = slot / sps;
      v = (int'(fbytes[i][sym / syms]) >> (m * (sym % syms))) & ((1 << m) - 1);
      return (slot % sps) != (2 * v + 1);
    end
    return (slot - ds) != 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mhead[i] = 0; mtail[i] = 0; fact[i] = 0; fcyc[i] = 0;
        mdone[i] = 0; merr[i] = 0; flen[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int  cnt, pc, len;
        bit  was, acc;
        cnt = mtail[i] - mhead[i];
        was = fact[i];
        pc  = fcyc[i];
        len = int'(frame_len[i]);
        mdone[i] = 0;
        merr[i]  = 0;
        if (s_valid[i] && cnt < 16) begin
          mbuf[i][mtail[i] % 256] = s_data[i];
          mtail[i]++;
        end
        if (was) begin
          for (int b = 0; b < flen[i]; b++)
            if (pc == pop_time(i, b)) mhead[i]++;
          if (pc == frame_total(i, flen[i]) - 1) begin
            fact[i]  = 0;
            mdone[i] = 1;
          end else begin
            fcyc[i] = pc + 1;
          end
        end
        if (start[i]) begin
          acc = !was && len >= 1 && len <= 16 && cnt >= len;
          if (acc) begin
            fact[i] = 1;
            fcyc[i] = 0;
            flen[i] = len;
            for (int b = 0; b < len; b++) fbytes[i][b] = mbuf[i][(mhead[i] + b) % 256];
          end else begin
            merr[i] = 1;
          end
        end
      end
    end
  end

  task automatic cmp(int i, string name, int act, int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  task automatic fail(int i, string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s dut%0d t=%0t: wait bound expired", name, i, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        cmp(i, "dout",       int'(dout[i]),       fact[i] ? int'(exp_dout(i, fcyc[i])) : 1);
        cmp(i, "busy",       int'(busy[i]),       int'(fact[i]));
        cmp(i, "done",       int'(done[i]),       int'(mdone[i]));
        cmp(i, "err_start",  int'(err_start[i]),  int'(merr[i]));
        cmp(i, "fifo_count", int'(fifo_count[i]), mtail[i] - mhead[i]);
        cmp(i, "s_ready",    int'(s_ready[i]),    int'((mtail[i] - mhead[i]) < 16));
      end
    end
  end

  // ---------------- literal frame expectations ----------------
  int exp_falls [4][12] = '{
    '{0, 80, 240, 336, 432, 528, 672, 0, 0, 0, 0, 0},
    '{0, 20, 44, 52, 76, 84, 100, 124, 132, 156, 168, 0},
    '{0, 20, 76, 244, 296, 0, 0, 0, 0, 0, 0, 0},
    '{0, 80, 240, 272, 400, 624, 672, 0, 0, 0, 0, 0}};
  int exp_nf [4]   = '{7, 11, 5, 7};
  int exp_done [4] = '{704, 176, 304, 704};

  int falls [32];
  int nfalls, done_at, cnt_at_done;

  task automatic push(int i, logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready[i] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready[i]) fail(i, "push_wait");
    s_data[i]  = d;
    s_valid[i] = 1'b1;
    @(posedge clk);
    #1 s_valid[i] = 1'b0;
  endtask

  task automatic pulse_start(int i, int len);
    @(negedge clk);
    start[i]     = 1'b1;
    frame_len[i] = 5'(len);
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  task automatic run_frame(int i, int len);
    int   c;
    logic prev;
    nfalls = 0; done_at = -1; prev = 1'b1; c = 0;
    pulse_start(i, len);
    while (done_at < 0 && c < 20000) begin
      @(negedge clk);
      if (dout[i] === 1'b0 && prev === 1'b1 && nfalls < 32) begin
        falls[nfalls] = c;
        nfalls++;
      end
      prev = dout[i];
      if (done[i] === 1'b1) begin
        done_at     = c;
        cnt_at_done = int'(fifo_count[i]);
      end
      c++;
    end
    if (done_at < 0) fail(i, "frame_done_wait");
  endtask

  task automatic check_frame(int i, int row);
    cmp(i, "fall_count", nfalls, exp_nf[row]);
    for (int k = 0; k < exp_nf[row]; k++) cmp(i, "fall_cycle", falls[k], exp_falls[row][k]);
    cmp(i, "done_cycle", done_at, exp_done[row]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 3; i++) begin
      s_data[i] = 8'h00; s_valid[i] = 1'b0; start[i] = 1'b0; frame_len[i] = 5'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    cmp(0, "rst_dout",       int'(dout[0]),       1);
    cmp(0, "rst_s_ready",    int'(s_ready[0]),    1);
    cmp(0, "rst_busy",       int'(busy[0]),       0);
    cmp(0, "rst_done",       int'(done[0]),       0);
    cmp(0, "rst_err_start",  int'(err_start[0]),  0);
    cmp(0, "rst_fifo_count", int'(fifo_count[0]), 0);

    // single byte, M=2 S=16
    push(0, 8'h1B);
    run_frame(0, 1);
    check_frame(0, 0);

    // M=1 and M=4 with 0xA5
    push(1, 8'hA5);
    run_frame(1, 1);
    check_frame(1, 1);
    push(2, 8'hA5);
    run_frame(2, 1);
    check_frame(2, 2);

    // rejection: too long, then zero length
    push(0, 8'h11);
    push(0, 8'h22);
    pulse_start(0, 3);
    @(negedge clk);
    cmp(0, "rej_err",  int'(err_start[0]), 1);
    cmp(0, "rej_busy", int'(busy[0]),      0);
    cmp(0, "rej_dout", int'(dout[0]),      1);
    pulse_start(0, 0);
    @(negedge clk);
    cmp(0, "rej0_err",  int'(err_start[0]), 1);
    cmp(0, "rej0_busy", int'(busy[0]),      0);
    @(negedge clk);
    cmp(0, "rej_err_pulse", int'(err_start[0]), 0);

    // fill, overflow attempt, 16-byte frame across the wrap with pushes in flight
    for (int k = 0; k < 14; k++) push(0, 8'(48 + k));
    @(negedge clk);
    cmp(0, "full_count", int'(fifo_count[0]), 16);
    cmp(0, "full_ready", int'(s_ready[0]),    0);
    s_data[0]  = 8'hEE;
    s_valid[0] = 1'b1;
    @(posedge clk);
    #1 s_valid[0] = 1'b0;
    @(negedge clk);
    cmp(0, "overflow_count", int'(fifo_count[0]), 16);
    fork
      run_frame(0, 16);
      begin
        for (int k = 0; k < 5; k++) push(0, 8'(96 + k));
      end
    join
    cmp(0, "wrap_done_cycle", done_at,     8384);
    cmp(0, "wrap_count_done", cnt_at_done, 5);

    // reset during a DATA pulse
    pulse_start(0, 2);
    c = 0;
    while (c < 2000 && !(c >= 140 && dout[0] === 1'b0)) begin
      @(negedge clk);
      c++;
    end
    if (dout[0] !== 1'b0) fail(0, "data_pulse_wait");
    #2 rst = 1'b1;
    #1;
    cmp(0, "arst_dout",  int'(dout[0]),       1);
    cmp(0, "arst_count", int'(fifo_count[0]), 0);
    cmp(0, "arst_busy",  int'(busy[0]),       0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      cmp(0, "arst_no_done", int'(done[0]), 0);
    end
    push(0, 8'hC3);
    run_frame(0, 1);
    check_frame(0, 3);

    // back-to-back frames
    push(0, 8'h5A);
    push(0, 8'h3C);
    pulse_start(0, 1);
    c = 0;
    while (c < 2000 && done[0] !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    if (done[0] !== 1'b1) fail(0, "b2b_first_done");
    cmp(0, "b2b_first_done_cycle", c - 1, 704);
    start[0]     = 1'b1;
    frame_len[0] = 5'd1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    @(negedge clk);
    cmp(0, "b2b_busy", int'(busy[0]), 1);
    cmp(0, "b2b_sof",  int'(dout[0]), 0);
    c = 0;
    while (c < 2000 && done[0] !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    if (done[0] !== 1'b1) fail(0, "b2b_second_done");
    cmp(0, "b2b_second_done_cycle", c, 704);
    @(negedge clk);
    cmp(0, "end_count", int'(fifo_count[0]), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
